// File: rtl/text_pkg.sv
// Shared widths, attribute layout and font pattern for the text-mode glyph pipeline.
// Pure declarations: no latency, no flow control.
package text_pkg;

  typedef struct packed {
    logic blink;
    logic underline;
  } attr_flags_t;

  localparam int CHAR_BLANK = 32'h20;
  localparam int CHAR_SOLID = 32'hDB;

  function automatic int attr_width(input int color_bits);
    return 2 * color_bits + 2;
  endfunction

  function automatic int x_width(input int glyph_w);
    return $clog2(glyph_w) + 1;
  endfunction

  function automatic int y_width(input int glyph_h);
    return $clog2(glyph_h) + 1;
  endfunction

  // Attribute is packed MSB first as {blink, underline, bg, fg}.
  function automatic int attr_fg_lsb(input int color_bits);
    return 0 * color_bits;
  endfunction

  function automatic int attr_bg_lsb(input int color_bits);
    return color_bits;
  endfunction

  function automatic int attr_ul_pos(input int color_bits);
    return 2 * color_bits;
  endfunction

  function automatic int attr_blink_pos(input int color_bits);
    return 2 * color_bits + 1;
  endfunction

  // Built-in font image: blank and solid cells are exact, other codes get a fixed scramble.
  function automatic logic [15:0] glyph_pattern(input int code, input int row);
    if (code == CHAR_BLANK) return 16'h0000;
    if (code == CHAR_SOLID) return 16'hFFFF;
    return 16'((code * 157) ^ (row * 53) ^ 90);
  endfunction

endpackage

// File: rtl/text_glyph_pipeline_glyph_rom.sv
// Synchronous-read glyph ROM addressed by {char, row}; 1-cycle read latency, read only when en=1.
// No backpressure: the output register simply holds its last row while en=0.
module glyph_rom
  import text_pkg::*;
#(
  parameter int CHAR_BITS = 8,
  parameter int GLYPH_W   = 8,
  parameter int GLYPH_H   = 16
) (
  input  logic                                  clk,
  input  logic                                  en,
  input  logic [CHAR_BITS+$clog2(GLYPH_H)-1:0]  addr,
  output logic [GLYPH_W-1:0]                    data
);

  localparam int ROW_BITS = $clog2(GLYPH_H);

  logic [GLYPH_W-1:0] data_d;
  logic [GLYPH_W-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = GLYPH_W'(glyph_pattern(int'(addr[ROW_BITS +: CHAR_BITS]),
                                      int'(addr[ROW_BITS-1:0])));
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/text_glyph_pipeline.sv
// Text-mode pixel renderer: char/attr/x/y in, palette index out, fixed 2-cycle latency.
// No backpressure: one request per cycle, valid bit travels with the data.
module text_glyph_pipeline
  import text_pkg::*;
#(
  parameter int GLYPH_W       = 8,
  parameter int GLYPH_H       = 16,
  parameter int CHAR_BITS     = 8,
  parameter int COLOR_BITS    = 4,
  parameter int BLINK_FRAMES  = 16,
  parameter int UNDERLINE_ROW = 15,
  parameter int CURSOR_FIRST  = 14,
  parameter int CURSOR_LAST   = 15
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [CHAR_BITS-1:0]                char_code,
  input  logic [attr_width(COLOR_BITS)-1:0]   attr,
  input  logic [x_width(GLYPH_W)-1:0]         x,
  input  logic [y_width(GLYPH_H)-1:0]         y,
  input  logic                                cursor,
  input  logic                                frame_tick,
  output logic                                out_valid,
  output logic [COLOR_BITS-1:0]               out_color,
  output logic                                out_fg
);

  localparam int XW = x_width(GLYPH_W);
  localparam int YW = y_width(GLYPH_H);
  localparam int YB = $clog2(GLYPH_H);
  localparam int FW = $clog2(BLINK_FRAMES) + 1;

  logic [FW-1:0]         frame_cnt_d, frame_cnt_q;

  logic                  s1_vld_d, s1_vld_q;
  logic [XW-1:0]         s1_x_d, s1_x_q;
  logic [YW-1:0]         s1_y_d, s1_y_q;
  attr_flags_t           s1_flags_d, s1_flags_q;
  logic [COLOR_BITS-1:0] s1_fg_d, s1_fg_q;
  logic [COLOR_BITS-1:0] s1_bg_d, s1_bg_q;
  logic                  s1_cursor_d, s1_cursor_q;
  logic                  s1_cur_ph_d, s1_cur_ph_q;
  logic                  s1_chr_ph_d, s1_chr_ph_q;

  logic                  out_valid_d, out_valid_q;
  logic [COLOR_BITS-1:0] out_color_d, out_color_q;
  logic                  out_fg_d, out_fg_q;

  logic [GLYPH_W-1:0]    rom_data;
  logic                  pix;

  glyph_rom #(
    .CHAR_BITS (CHAR_BITS),
    .GLYPH_W   (GLYPH_W),
    .GLYPH_H   (GLYPH_H)
  ) u_rom (
    .clk  (clk),
    .en   (in_valid),
    .addr ({char_code, y[YB-1:0]}),
    .data (rom_data)
  );

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_tick) frame_cnt_d = frame_cnt_q + FW'(1);
  end

  // Phases are sampled from the pre-increment count so a coincident tick affects the next request.
  always_comb begin
    s1_vld_d    = in_valid;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    s1_flags_d  = s1_flags_q;
    s1_fg_d     = s1_fg_q;
    s1_bg_d     = s1_bg_q;
    s1_cursor_d = s1_cursor_q;
    s1_cur_ph_d = s1_cur_ph_q;
    s1_chr_ph_d = s1_chr_ph_q;
    if (in_valid) begin
      s1_x_d               = x;
      s1_y_d               = y;
      s1_flags_d.blink     = attr[attr_blink_pos(COLOR_BITS)];
      s1_flags_d.underline = attr[attr_ul_pos(COLOR_BITS)];
      s1_fg_d              = attr[attr_fg_lsb(COLOR_BITS) +: COLOR_BITS];
      s1_bg_d              = attr[attr_bg_lsb(COLOR_BITS) +: COLOR_BITS];
      s1_cursor_d          = cursor;
      s1_cur_ph_d          = frame_cnt_q[FW-2];
      s1_chr_ph_d          = frame_cnt_q[FW-1];
    end
  end

  always_comb begin
    pix = 1'b0;
    for (int c = 0; c < GLYPH_W; c++) begin
      if (s1_x_q == XW'(c)) pix = rom_data[GLYPH_W-1-c];
    end
    if (s1_y_q >= YW'(GLYPH_H)) pix = 1'b0;
    if (s1_flags_q.underline && (s1_y_q == YW'(UNDERLINE_ROW))) pix = 1'b1;
    if (s1_flags_q.blink && s1_chr_ph_q) pix = 1'b0;
    // Cursor goes last and ignores the gap-column rule so the block spans the whole cell.
    if (s1_cursor_q && !s1_cur_ph_q &&
        (s1_y_q >= YW'(CURSOR_FIRST)) && (s1_y_q <= YW'(CURSOR_LAST))) pix = ~pix;
  end

  always_comb begin
    out_valid_d = s1_vld_q;
    out_color_d = out_color_q;
    out_fg_d    = out_fg_q;
    if (s1_vld_q) begin
      out_color_d = pix ? s1_fg_q : s1_bg_q;
      out_fg_d    = pix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      s1_vld_q    <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_flags_q  <= '0;
      s1_fg_q     <= '0;
      s1_bg_q     <= '0;
      s1_cursor_q <= 1'b0;
      s1_cur_ph_q <= 1'b0;
      s1_chr_ph_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_color_q <= '0;
      out_fg_q    <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      s1_vld_q    <= s1_vld_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_flags_q  <= s1_flags_d;
      s1_fg_q     <= s1_fg_d;
      s1_bg_q     <= s1_bg_d;
      s1_cursor_q <= s1_cursor_d;
      s1_cur_ph_q <= s1_cur_ph_d;
      s1_chr_ph_q <= s1_chr_ph_d;
      out_valid_q <= out_valid_d;
      out_color_q <= out_color_d;
      out_fg_q    <= out_fg_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_color = out_color_q;
  assign out_fg    = out_fg_q;

endmodule

// File: tb/tb_text_glyph_pipeline.sv
// Directed and randomized bench for text_glyph_pipeline with a rule-level pixel model.
module tb_text_glyph_pipeline;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] char_code;
  logic [9:0] attr;
  logic [3:0] x;
  logic [4:0] y;
  logic       cursor;
  logic       frame_tick;
  logic       out_valid;
  logic [3:0] out_color;
  logic       out_fg;

  always #5 clk = ~clk;

  text_glyph_pipeline dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .char_code  (char_code),
    .attr       (attr),
    .x          (x),
    .y          (y),
    .cursor     (cursor),
    .frame_tick (frame_tick),
    .out_valid  (out_valid),
    .out_color  (out_color),
    .out_fg     (out_fg)
  );

  int checks = 0;
  int errors = 0;
  int m_ticks = 0;

  // Expected results in flight: index 0 was driven last call, index 1 is due now.
  bit       p_v [2];
  bit [3:0] p_c [2];
  bit       p_f [2];

  function automatic int ref_row(input int c, input int r);
    if (c == 'h20) return 0;
    if (c == 'hDB) return 255;
    return ((c * 157) ^ (r * 53) ^ 90) & 255;
  endfunction

  function automatic bit ref_pixel(input int c, input int a, input int xx, input int yy,
                                   input bit cur, input int ticks);
    bit b;
    b = 1'b0;
    if (xx < 8 && yy < 16) b = ((ref_row(c, yy) >> (7 - xx)) & 1) != 0;
    if (((a >> 8) & 1) != 0 && yy == 15) b = 1'b1;
    if (((a >> 9) & 1) != 0 && (ticks % 32) >= 16) b = 1'b0;
    if (cur && (ticks % 16) < 8 && yy >= 14 && yy <= 15) b = !b;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit v, input int c, input int a, input int xx, input int yy,
                       input bit cur, input bit tick, input bit r);
    bit b;
    @(negedge clk);
    chk("out_valid", {31'b0, out_valid}, {31'b0, p_v[1]});
    if (p_v[1]) begin
      chk("out_color", {28'b0, out_color}, {28'b0, p_c[1]});
      chk("out_fg", {31'b0, out_fg}, {31'b0, p_f[1]});
    end
    in_valid   = v;
    char_code  = 8'(c);
    attr       = 10'(a);
    x          = 4'(xx);
    y          = 5'(yy);
    cursor     = cur;
    frame_tick = tick;
    rst        = r;
    b = ref_pixel(c, a, xx, yy, cur, m_ticks);
    p_v[1] = p_v[0];
    p_c[1] = p_c[0];
    p_f[1] = p_f[0];
    p_v[0] = v && !r;
    p_c[0] = b ? 4'(a) : 4'(a >> 4);
    p_f[0] = b;
    if (r) begin
      p_v[1]  = 1'b0;
      m_ticks = 0;
    end else if (tick) begin
      m_ticks++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    int c;
    p_v[0] = 0; p_v[1] = 0; p_c[0] = 0; p_c[1] = 0; p_f[0] = 0; p_f[1] = 0;
    rst = 1'b1; in_valid = 1'b0; char_code = '0; attr = '0; x = '0; y = '0;
    cursor = 1'b0; frame_tick = 1'b0;

    // Reset state, with frame_tick held high to show it is ignored during reset.
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 1, 1);
    chk("rst_out_color", {28'b0, out_color}, 32'd0);
    chk("rst_out_fg", {31'b0, out_fg}, 32'd0);

    // 'A' with fg=F bg=1, every pixel back-to-back.
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 8; xx++)
        cycle(1, 'h41, 'h01F, xx, yy, 0, 0, 0);
    idle(2);

    // Gap column on a solid glyph, plain and under the cursor.
    cycle(1, 'hDB, 'h01F, 8, 3, 0, 0, 0);
    cycle(1, 'hDB, 'h01F, 8, 14, 1, 0, 0);
    cycle(1, 'hDB, 'h01F, 9, 20, 0, 0, 0);
    idle(2);

    // Underline alone, then with blink in char phase 1, then after the counter wraps.
    cycle(1, 'h20, 'h11F, 3, 15, 0, 0, 0);
    ticks(16);
    cycle(1, 'h20, 'h31F, 3, 15, 0, 0, 0);
    cycle(1, 'h20, 'h11F, 3, 15, 0, 0, 0);
    ticks(16);
    cycle(1, 'h20, 'h31F, 3, 15, 0, 0, 0);
    idle(2);

    // Cursor blink across one full cursor period.
    for (int t = 0; t <= 16; t++) begin
      cycle(1, 'h20, 'h01F, 2, 14, 1, 0, 0);
      cycle(1, 'h20, 'h01F, 2, 13, 1, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
    end
    idle(2);

    // Phase snapshot across the 7 -> 8 boundary.
    while ((m_ticks % 16) != 7) ticks(1);
    cycle(1, 'h20, 'h01F, 0, 14, 1, 1, 0);
    cycle(1, 'h20, 'h01F, 0, 14, 1, 0, 0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       c = 'h20;
        1:       c = 'hDB;
        2:       c = 'h41;
        default: c = int'($urandom_range(0, 255));
      endcase
      cycle(($urandom_range(0, 3) != 0), c, int'($urandom_range(0, 1023)),
            int'($urandom_range(0, 9)), int'($urandom_range(0, 17)),
            bit'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), 0);
    end
    idle(2);

    // Mid-stream reset with the cursor in its off phase; the post-reset request sees count 0.
    while ((m_ticks % 16) < 8) ticks(1);
    cycle(1, 'hDB, 'h01F, 0, 0, 0, 0, 0);
    cycle(1, 'hDB, 'h01F, 1, 0, 0, 1, 1);
    cycle(1, 'h20, 'h01F, 0, 14, 1, 0, 0);
    chk("midrst_out_color", {28'b0, out_color}, 32'd0);
    chk("midrst_out_fg", {31'b0, out_fg}, 32'd0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
